board_position_tracker: RTL and testbench

Datapath stage directly upstream of the game FSM controller. Holds the 3x3 tic-tac-toe board and applies moves when the controller grants a turn. Produces the illegal_move, no_space and win status the controller consumes, plus the winner identity and a board snapshot for display logic.

---
 rtl/tictactoe_pkg.sv | 41 ++++
 rtl/win_line_detector.sv | 28 ++
 rtl/board_position_tracker.sv | 138 +++++++++++++
 tb/tb_board_position_tracker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
// +--------------------------------------------------------------------------+
// | Package : tictactoe_pkg                                                    |
// | Brief   : Cell/winner encodings, board size and the 8-line lookup table.   |
// | Rev     : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package tictactoe_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b01,
        CELL_O     = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        WINNER_NONE = 2'b00,
        WINNER_X    = 2'b01,
        WINNER_O    = 2'b10
    } winner_t;

    localparam int N_CELLS   = 9;
    localparam int LAST_POS  = 8;
    localparam int N_LINES   = 8;
    localparam int MOVES_MAX = 9;

    // Index order matches the win_line bit order: rows, columns, 0-4-8, 2-4-6.
    localparam logic [N_LINES-1:0][2:0][3:0] LINE_TABLE = {
        {4'd6, 4'd4, 4'd2},
        {4'd8, 4'd4, 4'd0},
        {4'd8, 4'd5, 4'd2},
        {4'd7, 4'd4, 4'd1},
        {4'd6, 4'd3, 4'd0},
        {4'd8, 4'd7, 4'd6},
        {4'd5, 4'd4, 4'd3},
        {4'd2, 4'd1, 4'd0}
    };

endpackage

`default_nettype wire

// File: rtl/win_line_detector.sv
// +--------------------------------------------------------------------------+
// | Module  : win_line_detector                                                |
// | Brief   : Flags every board line fully owned by the given player code.    |
// | Rev     : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module win_line_detector
    import tictactoe_pkg::*;
(
    input  logic [2*N_CELLS-1:0] i_board,
    input  logic [1:0]           i_player,
    output logic [N_LINES-1:0]   o_hits
);

    for (genvar l = 0; l < N_LINES; l++) begin : g_line
        localparam int C_A = int'(LINE_TABLE[l][0]);
        localparam int C_B = int'(LINE_TABLE[l][1]);
        localparam int C_C = int'(LINE_TABLE[l][2]);

        assign o_hits[l] = (i_board[2*C_A +: 2] == i_player) &&
                           (i_board[2*C_B +: 2] == i_player) &&
                           (i_board[2*C_C +: 2] == i_player);
    end

endmodule

`default_nettype wire

// File: rtl/board_position_tracker.sv
// +--------------------------------------------------------------------------+
// | Module  : board_position_tracker                                           |
// | Brief   : 3x3 board store, move legality and registered win/draw status.  |
// |           Optional macro WIN_LINE_EN adds the one-hot win_line output.     |
// | Rev     : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module board_position_tracker
    import tictactoe_pkg::*;
#(
    parameter int POS_W = 4
)
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 player_O_play,
    input  logic                 player_X_play,
    input  logic [POS_W-1:0]     pos_O,
    input  logic [POS_W-1:0]     pos_X,
    output logic                 illegal_move,
    output logic                 no_space,
    output logic                 win,
    output logic [1:0]           winner,
    output logic [2*N_CELLS-1:0] board,
    output logic [3:0]           move_count
`ifdef WIN_LINE_EN
    ,
    output logic [N_LINES-1:0]   win_line
`endif
);

    logic [2*N_CELLS-1:0] r_board;
    logic [3:0]           r_move_count;
    logic                 r_win;
    logic [1:0]           r_winner;
    logic                 r_no_space;

    logic                 w_any_play;
    logic                 w_both_play;
    logic [POS_W-1:0]     w_target;
    logic [1:0]           w_code;
    logic                 w_target_occupied;
    logic                 w_illegal;
    logic                 w_accept;
    logic [N_LINES-1:0]   w_hits_x;
    logic [N_LINES-1:0]   w_hits_o;
    logic                 w_line_hit;

    assign w_any_play  = player_O_play | player_X_play;
    assign w_both_play = player_O_play & player_X_play;
    assign w_target    = player_O_play ? pos_O : pos_X;
    assign w_code      = player_O_play ? CELL_O : CELL_X;

    // Out-of-range targets match no cell and are caught by the range check.
    always_comb begin
        w_target_occupied = 1'b0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (w_target == POS_W'(i)) begin
                w_target_occupied = (r_board[2*i +: 2] != CELL_EMPTY);
            end
        end
    end

    assign w_illegal = w_any_play &&
                       (w_both_play || (w_target > POS_W'(LAST_POS)) ||
                        w_target_occupied || r_win);
    assign w_accept  = w_any_play && !w_illegal;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_board      <= '0;
            r_move_count <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < N_CELLS; i++) begin
                if (w_target == POS_W'(i)) begin
                    r_board[2*i +: 2] <= w_code;
                end
            end
            if (r_move_count != 4'(MOVES_MAX)) begin
                r_move_count <= r_move_count + 4'd1;
            end
        end
    end

    win_line_detector u_detect_x (
        .i_board  (r_board),
        .i_player (CELL_X),
        .o_hits   (w_hits_x)
    );

    win_line_detector u_detect_o (
        .i_board  (r_board),
        .i_player (CELL_O),
        .o_hits   (w_hits_o)
    );

    assign w_line_hit = |(w_hits_x | w_hits_o);

    // Only one cell changes per edge, so X and O can never hit together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_win      <= 1'b0;
            r_winner   <= WINNER_NONE;
            r_no_space <= 1'b0;
        end else begin
            r_no_space <= (r_move_count == 4'(MOVES_MAX));
            if (!r_win && w_line_hit) begin
                r_win    <= 1'b1;
                r_winner <= (|w_hits_x) ? WINNER_X : WINNER_O;
            end
        end
    end

`ifdef WIN_LINE_EN
    logic [N_LINES-1:0] r_win_line;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_win_line <= '0;
        end else if (!r_win && w_line_hit) begin
            r_win_line <= w_hits_x | w_hits_o;
        end
    end

    assign win_line = r_win_line;
`endif

    assign illegal_move = w_illegal;
    assign no_space     = r_no_space;
    assign win          = r_win;
    assign winner       = r_winner;
    assign board        = r_board;
    assign move_count   = r_move_count;

endmodule

`default_nettype wire

// File: tb/tb_board_position_tracker.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_board_position_tracker                                        |
// | Brief   : Directed self-checking bench for board_position_tracker.        |
// | Rev     : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_board_position_tracker;

    logic        clock;
    logic        reset;
    logic        player_O_play;
    logic        player_X_play;
    logic [3:0]  pos_O;
    logic [3:0]  pos_X;
    logic        illegal_move;
    logic        no_space;
    logic        win;
    logic [1:0]  winner;
    logic [17:0] board;
    logic [3:0]  move_count;
`ifdef WIN_LINE_EN
    logic [7:0]  win_line;
`endif

    int n_checks;
    int n_fail;

    board_position_tracker #(.POS_W(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .player_O_play (player_O_play),
        .player_X_play (player_X_play),
        .pos_O         (pos_O),
        .pos_X         (pos_X),
        .illegal_move  (illegal_move),
        .no_space      (no_space),
        .win           (win),
        .winner        (winner),
        .board         (board),
        .move_count    (move_count)
`ifdef WIN_LINE_EN
        ,
        .win_line      (win_line)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Grant one move at the negedge, check illegal_move, then let the edge apply it.
    task automatic play(input bit is_o, input logic [3:0] pos, input bit exp_illegal, input string tag);
        @(negedge clock);
        player_O_play = is_o;
        player_X_play = !is_o;
        pos_O = pos;
        pos_X = pos;
        #1 check_eq(tag, 32'(illegal_move), 32'(exp_illegal));
        @(posedge clock);
        #1;
        player_O_play = 1'b0;
        player_X_play = 1'b0;
    endtask

    task automatic mid_cycle_reset();
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check_eq("rst_board", 32'(board), 32'h0);
        check_eq("rst_count", 32'(move_count), 32'h0);
        check_eq("rst_win", 32'(win), 32'h0);
        check_eq("rst_winner", 32'(winner), 32'h0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b0;
        player_O_play = 1'b0;
        player_X_play = 1'b0;
        pos_O = 4'd0;
        pos_X = 4'd0;

        // Reset held while grants toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            player_O_play = i[0];
            player_X_play = !i[0];
            pos_O = 4'd4;
            pos_X = 4'd2;
        end
        @(negedge clock);
        player_O_play = 1'b1;
        player_X_play = 1'b1;
        #1 check_eq("both_in_reset_illegal", 32'(illegal_move), 32'h1);
        check_eq("reset_board", 32'(board), 32'h0);
        check_eq("reset_count", 32'(move_count), 32'h0);
        check_eq("reset_win", 32'(win), 32'h0);
        check_eq("reset_nospace", 32'(no_space), 32'h0);
        check_eq("reset_winner", 32'(winner), 32'h0);
        player_O_play = 1'b0;
        player_X_play = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        next_edge();
        next_edge();
        check_eq("idle_board", 32'(board), 32'h0);
        check_eq("idle_count", 32'(move_count), 32'h0);
        check_eq("idle_no_grant_legal", 32'(illegal_move), 32'h0);

        // Two legal moves
        play(1'b1, 4'd4, 1'b0, "o4_legal");
        play(1'b0, 4'd0, 1'b0, "x0_legal");
        check_eq("two_moves_board", 32'(board), 32'h00201);
        check_eq("two_moves_count", 32'(move_count), 32'd2);

        // Rejections: occupied, out of range, both enables
        play(1'b1, 4'd4, 1'b1, "o4_occupied");
        check_eq("occupied_board", 32'(board), 32'h00201);
        check_eq("occupied_count", 32'(move_count), 32'd2);
        play(1'b0, 4'd9, 1'b1, "x9_range");
        play(1'b0, 4'd15, 1'b1, "x15_range");
        @(negedge clock);
        player_O_play = 1'b1;
        player_X_play = 1'b1;
        pos_O = 4'd5;
        pos_X = 4'd6;
        #1 check_eq("both_enables", 32'(illegal_move), 32'h1);
        next_edge();
        player_O_play = 1'b0;
        player_X_play = 1'b0;
        check_eq("reject_board", 32'(board), 32'h00201);
        check_eq("reject_count", 32'(move_count), 32'd2);

        // O wins row 0
        mid_cycle_reset();
        play(1'b1, 4'd0, 1'b0, "w_o0");
        play(1'b0, 4'd3, 1'b0, "w_x3");
        play(1'b1, 4'd1, 1'b0, "w_o1");
        play(1'b0, 4'd4, 1'b0, "w_x4");
        play(1'b1, 4'd2, 1'b0, "w_o2");
        check_eq("win_latency", 32'(win), 32'h0);
        next_edge();
        check_eq("win_set", 32'(win), 32'h1);
        check_eq("winner_o", 32'(winner), 32'h2);
`ifdef WIN_LINE_EN
        check_eq("win_line_row0", 32'(win_line), 32'h01);
`endif
        play(1'b0, 4'd8, 1'b1, "post_win_grant");
        play(1'b1, 4'd5, 1'b1, "post_win_grant_o");
        check_eq("frozen_board", 32'(board), 32'h0016A);
        check_eq("frozen_count", 32'(move_count), 32'd5);
        check_eq("win_sticky", 32'(win), 32'h1);
        check_eq("winner_sticky", 32'(winner), 32'h2);

        // Draw
        mid_cycle_reset();
        play(1'b1, 4'd0, 1'b0, "d_o0");
        play(1'b0, 4'd1, 1'b0, "d_x1");
        play(1'b1, 4'd2, 1'b0, "d_o2");
        play(1'b0, 4'd4, 1'b0, "d_x4");
        play(1'b1, 4'd3, 1'b0, "d_o3");
        play(1'b0, 4'd5, 1'b0, "d_x5");
        play(1'b1, 4'd7, 1'b0, "d_o7");
        play(1'b0, 4'd6, 1'b0, "d_x6");
        play(1'b1, 4'd8, 1'b0, "d_o8");
        check_eq("draw_count", 32'(move_count), 32'd9);
        check_eq("nospace_latency", 32'(no_space), 32'h0);
        next_edge();
        check_eq("draw_nospace", 32'(no_space), 32'h1);
        check_eq("draw_win", 32'(win), 32'h0);
        check_eq("draw_winner", 32'(winner), 32'h0);
        check_eq("draw_board", 32'(board), 32'h295A6);
        play(1'b0, 4'd4, 1'b1, "full_board_grant");
        check_eq("full_count", 32'(move_count), 32'd9);

        // Reset mid-game after four moves, then X wins column 0
        mid_cycle_reset();
        play(1'b1, 4'd0, 1'b0, "m_o0");
        play(1'b0, 4'd1, 1'b0, "m_x1");
        play(1'b1, 4'd2, 1'b0, "m_o2");
        play(1'b0, 4'd4, 1'b0, "m_x4");
        mid_cycle_reset();
        check_eq("rst_nospace", 32'(no_space), 32'h0);
        play(1'b1, 4'd4, 1'b0, "new_o4");
        check_eq("new_game_board", 32'(board), 32'h00200);
        check_eq("new_game_count", 32'(move_count), 32'd1);
        play(1'b0, 4'd0, 1'b0, "c_x0");
        play(1'b1, 4'd1, 1'b0, "c_o1");
        play(1'b0, 4'd3, 1'b0, "c_x3");
        play(1'b1, 4'd2, 1'b0, "c_o2");
        play(1'b0, 4'd6, 1'b0, "c_x6");
        next_edge();
        check_eq("xwin_set", 32'(win), 32'h1);
        check_eq("winner_x", 32'(winner), 32'h1);
`ifdef WIN_LINE_EN
        check_eq("win_line_col0", 32'(win_line), 32'h08);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
